// File: rtl/goe_np.sv
// Per-port packet gate: forwards or drops tagged beat streams according to port_en at each head.
// Optional per-port good/drop counters are built only when GOE_NP_CNT_EN is defined.
module goe_np #(
  parameter int unsigned PORT_NUM = 4,
  parameter int unsigned DATA_W   = 134,
  parameter int unsigned CNT_W    = 32,
  parameter logic [7:0]  LMID     = 8'd5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [PORT_NUM-1:0]          in_goe_data_wr,
  input  logic [PORT_NUM*DATA_W-1:0]   in_goe_data,
  input  logic [PORT_NUM-1:0]          in_goe_valid_wr,
  input  logic [PORT_NUM-1:0]          in_goe_valid,
  input  logic [PORT_NUM-1:0]          port_en,
  input  logic                         cnt_clr,
  output logic [PORT_NUM-1:0]          pktout_data_wr,
  output logic [PORT_NUM*DATA_W-1:0]   pktout_data,
  output logic [PORT_NUM-1:0]          pktout_data_valid_wr,
  output logic [PORT_NUM-1:0]          pktout_data_valid,
  output logic [PORT_NUM*CNT_W-1:0]    pkt_cnt,
  output logic [PORT_NUM*CNT_W-1:0]    drop_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  state_t              r_state [PORT_NUM];
  logic [PORT_NUM-1:0] r_pkt_fwd;

  state_t              w_next  [PORT_NUM];
  logic [1:0]          w_tag   [PORT_NUM];
  logic [PORT_NUM-1:0] w_head;
  logic [PORT_NUM-1:0] w_tail;
  logic [PORT_NUM-1:0] w_fwd_eff;
  logic [PORT_NUM-1:0] w_beat_fwd;
  logic [PORT_NUM-1:0] w_vwr_fwd;

  // A head decides the packet immediately, so its own beat and any coincident
  // valid_wr follow port_en rather than the stale pkt_fwd.
  always_comb begin
    w_head     = '0;
    w_tail     = '0;
    w_fwd_eff  = '0;
    w_beat_fwd = '0;
    w_vwr_fwd  = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      w_tag[i]      = in_goe_data[i*DATA_W + DATA_W - 2 +: 2];
      w_head[i]     = in_goe_data_wr[i] && (w_tag[i] == 2'b01);
      w_tail[i]     = in_goe_data_wr[i] && (w_tag[i] == 2'b10);
      w_fwd_eff[i]  = w_head[i] ? port_en[i] : r_pkt_fwd[i];
      w_beat_fwd[i] = w_head[i] ? port_en[i]
                                : (in_goe_data_wr[i] && (r_state[i] == FWD));
      w_vwr_fwd[i]  = in_goe_valid_wr[i] && w_fwd_eff[i];
      if (w_head[i])      w_next[i] = port_en[i] ? FWD : DROP;
      else if (w_tail[i]) w_next[i] = IDLE;
      else                w_next[i] = r_state[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PORT_NUM; i++) r_state[i] <= IDLE;
      r_pkt_fwd            <= '0;
      pktout_data_wr       <= '0;
      pktout_data          <= '0;
      pktout_data_valid_wr <= '0;
      pktout_data_valid    <= '0;
    end else begin
      r_pkt_fwd            <= (w_head & port_en) | (~w_head & r_pkt_fwd);
      pktout_data_wr       <= w_beat_fwd;
      pktout_data_valid_wr <= w_vwr_fwd;
      pktout_data_valid    <= w_vwr_fwd & in_goe_valid;
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
        r_state[i] <= w_next[i];
        if (w_beat_fwd[i])
          pktout_data[i*DATA_W +: DATA_W] <= in_goe_data[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef GOE_NP_CNT_EN
  logic [CNT_W-1:0] r_pkt_cnt  [PORT_NUM];
  logic [CNT_W-1:0] r_drop_cnt [PORT_NUM];
  logic             w_unused;

  assign w_unused = ^LMID;

  // Saturating counters; a coincident clear beats any increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
        r_pkt_cnt[i]  <= '0;
        r_drop_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < PORT_NUM; i++) begin
        if (cnt_clr) begin
          r_pkt_cnt[i]  <= '0;
          r_drop_cnt[i] <= '0;
        end else if (in_goe_valid_wr[i]) begin
          if (w_fwd_eff[i] && in_goe_valid[i] && (r_pkt_cnt[i] != '1))
            r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
          if (!w_fwd_eff[i] && (r_drop_cnt[i] != '1))
            r_drop_cnt[i] <= r_drop_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    pkt_cnt  = '0;
    drop_cnt = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      pkt_cnt[i*CNT_W +: CNT_W]  = r_pkt_cnt[i];
      drop_cnt[i*CNT_W +: CNT_W] = r_drop_cnt[i];
    end
  end
`else
  logic w_unused;

  assign w_unused = ^{cnt_clr, LMID};
  assign pkt_cnt  = '0;
  assign drop_cnt = '0;
`endif

endmodule
